// File: rtl/nes_vga_scanout.sv
// Pops NES palette indices from the PPU pixel FIFO and scans them out as 640x480@60 VGA,
// with 2x horizontal/vertical doubling through a one-line buffer and the 2C02 palette ROM.
module nes_vga_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned X_OFFSET = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       fifo_empty,
  input  logic [5:0] fifo_rd_data,
  output logic       fifo_re,
  input  logic       clr_underflow,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       frame_start,
  output logic       underflow
);

  localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] WIN_FIRST = 10'(X_OFFSET);
  localparam logic [9:0] WIN_END   = 10'(X_OFFSET + 512);
  // Pops lead the window by 8 counts so column k lands in the buffer before it is read.
  localparam logic [9:0] POP_FIRST = 10'(X_OFFSET - 8);
  localparam logic [9:0] POP_LAST  = 10'(X_OFFSET + 502);

  localparam logic [23:0] PALETTE [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

  // Stage 0: raster counters, fetch scheduling, line-buffer addressing
  logic [9:0]  r_h0, r_v0;
  logic        w_pop_due, w_in_win0;
  logic [7:0]  w_rd_col;

  // Fetch path
  logic        r_fifo_re, r_uf_pend, r_wr_v, r_wr_uf, r_underflow;
  logic [7:0]  r_wr_col;
  logic [5:0]  r_line_buf [256];

  // Stage 1 / stage 2 (outputs)
  logic        r_vld1, r_win1;
  logic [9:0]  r_h1, r_v1;
  logic [5:0]  r_idx1;
  logic [9:0]  r_hcount, r_vcount;
  logic        r_hs, r_vs, r_blank_n, r_frame_start;
  logic [23:0] r_rgb;

  assign w_pop_due = !r_v0[0] && (r_v0 < V_ACT) && (r_h0 >= POP_FIRST) &&
                     (r_h0 <= POP_LAST) && !r_h0[0];
  assign w_in_win0 = (r_h0 >= WIN_FIRST) && (r_h0 < WIN_END) && (r_v0 < V_ACT);
  assign w_rd_col  = 8'((r_h0 - WIN_FIRST) >> 1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_h0          <= '0;
      r_v0          <= '0;
      r_fifo_re     <= 1'b0;
      r_uf_pend     <= 1'b0;
      r_wr_v        <= 1'b0;
      r_wr_uf       <= 1'b0;
      r_wr_col      <= '0;
      r_underflow   <= 1'b0;
      r_vld1        <= 1'b0;
      r_win1        <= 1'b0;
      r_h1          <= '0;
      r_v1          <= '0;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
      r_rgb         <= '0;
    end else begin
      if (r_h0 == H_LAST) begin
        r_h0 <= '0;
        r_v0 <= (r_v0 == V_LAST) ? 10'd0 : r_v0 + 10'd1;
      end else begin
        r_h0 <= r_h0 + 10'd1;
      end

      // A due pop with an empty FIFO still consumes its column, filled with black (0x0F).
      r_fifo_re   <= w_pop_due && !fifo_empty;
      r_uf_pend   <= w_pop_due && fifo_empty;
      r_wr_v      <= r_fifo_re || r_uf_pend;
      r_wr_uf     <= r_uf_pend;
      r_underflow <= (w_pop_due && fifo_empty) || (r_underflow && !clr_underflow);
      if (r_h0 == 10'd0) begin
        r_wr_col <= '0;
      end else if (r_wr_v) begin
        r_wr_col <= r_wr_col + 8'd1;
      end

      r_vld1 <= 1'b1;
      r_h1   <= r_h0;
      r_v1   <= r_v0;
      r_win1 <= w_in_win0;

      // Outputs keep their reset values until the pipeline has refilled.
      if (r_vld1) begin
        r_hcount      <= r_h1;
        r_vcount      <= r_v1;
        r_hs          <= !((r_h1 >= HS_START) && (r_h1 < HS_END));
        r_vs          <= !((r_v1 >= VS_START) && (r_v1 < VS_END));
        r_blank_n     <= (r_h1 < H_ACT) && (r_v1 < V_ACT);
        r_frame_start <= (r_h1 == 10'd0) && (r_v1 == 10'd0);
        r_rgb         <= r_win1 ? PALETTE[r_idx1] : 24'h000000;
      end
    end
  end

  // Line buffer: written on even lines, read on both lines of the pair
  always_ff @(posedge clk) begin
    if (r_wr_v) begin
      r_line_buf[r_wr_col] <= r_wr_uf ? 6'h0F : fifo_rd_data;
    end
    r_idx1 <= r_line_buf[w_rd_col];
  end

  assign fifo_re     = r_fifo_re;
  assign underflow   = r_underflow;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank_n;
  assign vga_r       = r_rgb[23:16];
  assign vga_g       = r_rgb[15:8];
  assign vga_b       = r_rgb[7:0];
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_nes_vga_scanout.sv
// Directed bench for nes_vga_scanout; vertical timing shrunk to 15 lines per frame to keep runs short.
module tb_nes_vga_scanout;

  localparam int unsigned V_ACT_T  = 8;
  localparam int unsigned V_FP_T   = 2;
  localparam int unsigned V_SYNC_T = 2;
  localparam int unsigned V_BP_T   = 3;
  localparam int TMO = 13000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       fifo_empty = 1'b0;
  logic [5:0] fifo_rd_data = 6'd0;
  logic       clr_underflow = 1'b0;
  logic       fifo_re, vga_hs, vga_vs, vga_blank_n, frame_start, underflow;
  logic [7:0] vga_r, vga_g, vga_b;
  logic [9:0] hcount, vcount;
  logic [23:0] rgb;

  assign rgb = {vga_r, vga_g, vga_b};

  always #5 clk = ~clk;

  nes_vga_scanout #(
    .V_ACTIVE(V_ACT_T), .V_FP(V_FP_T), .V_SYNC(V_SYNC_T), .V_BP(V_BP_T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_re(fifo_re), .clr_underflow(clr_underflow), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hcount(hcount), .vcount(vcount), .frame_start(frame_start), .underflow(underflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  // FIFO model and timing monitor
  int cyc = 0, pop_n = 0, pops_frame = 0, pops_prev_frame = 0, consec = 0, re_empty = 0;
  int fs_last = 0, fs_period = 0, last_h0 = 0, line_len = 0;
  int hs_low_cur = 0, hs_width = 0, hs_fall_h = 0, vs_low_cur = 0, vs_width = 0, vs_fall_v = 0;
  int pops_line [15];
  logic prev_re = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1;
  logic [9:0] prev_h = 10'd0;

  always @(negedge clk) begin
    cyc++;
    if (frame_start) begin
      fs_period = cyc - fs_last;
      fs_last = cyc;
      pops_prev_frame = pops_frame;
      pops_frame = 0;
      for (int i = 0; i < 15; i++) pops_line[i] = 0;
    end
    if (fifo_re) begin
      if (fifo_empty) re_empty++;
      if (prev_re) consec++;
      fifo_rd_data = 6'(pop_n);
      pop_n++;
      pops_frame++;
      if (vcount < 10'd15) pops_line[vcount]++;
    end
    prev_re = fifo_re;
    if (hcount == 10'd0 && prev_h == 10'd799) begin
      line_len = cyc - last_h0;
      last_h0 = cyc;
    end
    prev_h = hcount;
    if (!vga_hs) begin
      if (prev_hs) hs_fall_h = int'(hcount);
      hs_low_cur++;
    end else if (!prev_hs) begin
      hs_width = hs_low_cur;
      hs_low_cur = 0;
    end
    prev_hs = vga_hs;
    if (!vga_vs) begin
      if (prev_vs) vs_fall_v = int'(vcount);
      vs_low_cur++;
    end else if (!prev_vs) begin
      vs_width = vs_low_cur;
      vs_low_cur = 0;
    end
    prev_vs = vga_vs;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_pos(input int v, input int h);
    int n = 0;
    while (!(int'(vcount) == v && int'(hcount) == h) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_pos v=%0d h=%0d: timeout, at v=%0d h=%0d", v, h, vcount, hcount);
    end
  endtask

  task automatic wait_fs(input string name, input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < lim);
    #1;
    chk(name, 32'(frame_start), 32'd1);
  endtask

  typedef struct {
    int v;
    int h;
    logic hs;
    logic vs;
    logic bn;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Frame-0 sample points; column k carries index k mod 64
    vecs.push_back('{0,   0, 1'b1, 1'b1, 1'b1, 24'h000000});
    vecs.push_back('{0,  63, 1'b1, 1'b1, 1'b1, 24'h000000});
    vecs.push_back('{0,  64, 1'b1, 1'b1, 1'b1, 24'h7C7C7C});
    vecs.push_back('{0,  65, 1'b1, 1'b1, 1'b1, 24'h7C7C7C});
    vecs.push_back('{0,  66, 1'b1, 1'b1, 1'b1, 24'h0000FC});
    vecs.push_back('{0,  67, 1'b1, 1'b1, 1'b1, 24'h0000FC});
    vecs.push_back('{0,  90, 1'b1, 1'b1, 1'b1, 24'h000000});
    vecs.push_back('{0,  94, 1'b1, 1'b1, 1'b1, 24'h000000});
    vecs.push_back('{0, 128, 1'b1, 1'b1, 1'b1, 24'hF8F8F8});
    vecs.push_back('{0, 152, 1'b1, 1'b1, 1'b1, 24'h00E8D8});
    vecs.push_back('{0, 160, 1'b1, 1'b1, 1'b1, 24'hFCFCFC});
    vecs.push_back('{0, 236, 1'b1, 1'b1, 1'b1, 24'hF83800});
    vecs.push_back('{0, 571, 1'b1, 1'b1, 1'b1, 24'hF8D8F8});
    vecs.push_back('{0, 576, 1'b1, 1'b1, 1'b1, 24'h000000});
    vecs.push_back('{0, 639, 1'b1, 1'b1, 1'b1, 24'h000000});
    vecs.push_back('{0, 640, 1'b1, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{0, 655, 1'b1, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{0, 656, 1'b0, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{0, 751, 1'b0, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{0, 752, 1'b1, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{1,  64, 1'b1, 1'b1, 1'b1, 24'h7C7C7C});
    vecs.push_back('{1,  65, 1'b1, 1'b1, 1'b1, 24'h7C7C7C});
    vecs.push_back('{1, 236, 1'b1, 1'b1, 1'b1, 24'hF83800});
    vecs.push_back('{1, 571, 1'b1, 1'b1, 1'b1, 24'hF8D8F8});
    vecs.push_back('{2, 194, 1'b1, 1'b1, 1'b1, 24'h0000FC});
    vecs.push_back('{2, 195, 1'b1, 1'b1, 1'b1, 24'h0000FC});
    vecs.push_back('{7, 100, 1'b1, 1'b1, 1'b1, 24'h0058F8});
    vecs.push_back('{8, 100, 1'b1, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{9, 700, 1'b0, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{10,  0, 1'b1, 1'b0, 1'b0, 24'h000000});
    vecs.push_back('{10,700, 1'b0, 1'b0, 1'b0, 24'h000000});
    vecs.push_back('{11,799, 1'b1, 1'b0, 1'b0, 24'h000000});
    vecs.push_back('{12,  0, 1'b1, 1'b1, 1'b0, 24'h000000});

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    chk("rst_hs", 32'(vga_hs), 32'd1);
    chk("rst_vs", 32'(vga_vs), 32'd1);
    chk("rst_blank_n", 32'(vga_blank_n), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_fifo_re", 32'(fifo_re), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_hcount", 32'(hcount), 32'd0);
    chk("rst_vcount", 32'(vcount), 32'd0);

    reset_n = 1'b1;
    wait_fs("fs_after_reset", 6);
    chk("first_hcount", 32'(hcount), 32'd0);
    chk("first_vcount", 32'(vcount), 32'd0);
    @(negedge clk);
    chk("step1_hcount", 32'(hcount), 32'd1);
    chk("step1_fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    chk("step2_hcount", 32'(hcount), 32'd2);
    chk("step2_vcount", 32'(vcount), 32'd0);

    foreach (vecs[i]) begin
      wait_pos(vecs[i].v, vecs[i].h);
      chk($sformatf("vec%0d_v%0d_h%0d_hs", i, vecs[i].v, vecs[i].h), 32'(vga_hs), 32'(vecs[i].hs));
      chk($sformatf("vec%0d_v%0d_h%0d_vs", i, vecs[i].v, vecs[i].h), 32'(vga_vs), 32'(vecs[i].vs));
      chk($sformatf("vec%0d_v%0d_h%0d_blank_n", i, vecs[i].v, vecs[i].h), 32'(vga_blank_n), 32'(vecs[i].bn));
      chk($sformatf("vec%0d_v%0d_h%0d_rgb", i, vecs[i].v, vecs[i].h), 32'(rgb), 32'(vecs[i].rgb));
    end

    // Frame 1: per-line fetch counts and timing statistics
    wait_fs("fs_frame1", TMO);
    wait_pos(3, 0);
    chk("pops_line0", 32'(pops_line[0]), 32'd256);
    chk("pops_line1", 32'(pops_line[1]), 32'd0);
    chk("pops_line2", 32'(pops_line[2]), 32'd256);
    wait_pos(14, 799);
    chk("pops_vblank", 32'(pops_line[8] + pops_line[9] + pops_line[10] + pops_line[11] +
                          pops_line[12] + pops_line[13] + pops_line[14]), 32'd0);
    wait_fs("fs_frame2", 4);
    chk("frame_period", 32'(fs_period), 32'd12000);
    chk("pops_per_frame", 32'(pops_prev_frame), 32'd1024);
    chk("line_period", 32'(line_len), 32'd800);
    chk("hs_width", 32'(hs_width), 32'd96);
    chk("hs_fall_h", 32'(hs_fall_h), 32'd656);
    chk("vs_width", 32'(vs_width), 32'd1600);
    chk("vs_fall_v", 32'(vs_fall_v), 32'd10);
    chk("no_consec_pops", 32'(consec), 32'd0);

    // Frame 2: FIFO empty for all of line 4
    wait_pos(4, 0);
    fifo_empty = 1'b1;
    wait_pos(4, 100);
    chk("uf_set", 32'(underflow), 32'd1);
    wait_pos(4, 200);
    chk("uf_l4_rgb", 32'(rgb), 32'd0);
    chk("uf_l4_blank_n", 32'(vga_blank_n), 32'd1);
    wait_pos(5, 0);
    fifo_empty = 1'b0;
    chk("uf_pops_line4", 32'(pops_line[4]), 32'd0);
    wait_pos(5, 64);
    chk("uf_l5_rgb64", 32'(rgb), 32'd0);
    wait_pos(5, 66);
    chk("uf_l5_rgb66", 32'(rgb), 32'd0);
    wait_pos(6, 66);
    chk("uf_l6_recover", 32'(rgb), 32'h0000FC);
    chk("uf_hold_l6", 32'(underflow), 32'd1);
    wait_pos(9, 0);
    chk("uf_hold_l9", 32'(underflow), 32'd1);
    clr_underflow = 1'b1;
    @(negedge clk);
    clr_underflow = 1'b0;
    chk("uf_cleared", 32'(underflow), 32'd0);
    @(negedge clk);
    chk("uf_stays_clear", 32'(underflow), 32'd0);

    // Frame 3: set underflow again, then reset mid-line on an active fetch line
    wait_fs("fs_frame3", TMO);
    wait_pos(2, 0);
    fifo_empty = 1'b1;
    wait_pos(3, 0);
    fifo_empty = 1'b0;
    chk("uf_set_again", 32'(underflow), 32'd1);
    wait_pos(4, 301);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mrst_fifo_re", 32'(fifo_re), 32'd0);
    chk("mrst_underflow", 32'(underflow), 32'd0);
    chk("mrst_hs", 32'(vga_hs), 32'd1);
    chk("mrst_vs", 32'(vga_vs), 32'd1);
    chk("mrst_blank_n", 32'(vga_blank_n), 32'd0);
    chk("mrst_rgb", 32'(rgb), 32'd0);
    chk("mrst_hcount", 32'(hcount), 32'd0);
    chk("mrst_vcount", 32'(vcount), 32'd0);
    chk("mrst_fs", 32'(frame_start), 32'd0);
    reset_n = 1'b1;
    wait_fs("mrst_fs_restart", 6);
    chk("mrst_restart_h", 32'(hcount), 32'd0);
    chk("mrst_restart_v", 32'(vcount), 32'd0);
    @(negedge clk);
    chk("mrst_restart_h1", 32'(hcount), 32'd1);
    wait_pos(1, 0);
    chk("mrst_pops_line0", 32'(pops_line[0]), 32'd256);
    chk("no_pop_when_empty", 32'(re_empty), 32'd0);
    chk("no_consec_pops_end", 32'(consec), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nes_vga_scanout.md
Name: nes_vga_scanout

Overview:
- Downstream consumer of the PPU pixel FIFO. Pops 6-bit NES palette indices and converts them to 24-bit RGB through the 2C02 palette ROM.
- Generates 640x480@60 VGA timing and displays the 256x240 NES frame at 2x horizontal and 2x vertical scale, centred horizontally.
- Even output lines are fetched from the FIFO and stored in a 256-entry line buffer. Odd output lines replay that buffer.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- X_OFFSET, 64, first hcount of the NES window (window = X_OFFSET .. X_OFFSET+511)

Ports:
- clk  in  1  pixel clock, one output pixel per cycle
- reset_n  in  1  synchronous, active-low reset
- fifo_empty  in  1  pixel FIFO empty flag
- fifo_rd_data  in  6  FIFO read data, valid the cycle after fifo_re=1 with fifo_empty=0
- fifo_re  out  1  FIFO pop request
- clr_underflow  in  1  clears the underflow flag
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_blank_n  out  1  1 inside the 640x480 active area
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- hcount  out  10  column of the pixel currently on the RGB outputs
- vcount  out  10  line of the pixel currently on the RGB outputs
- frame_start  out  1  one-cycle pulse while hcount=0 and vcount=0
- underflow  out  1  sticky FIFO-underflow flag

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Internal counters go to 0; pipeline flushed.
  - Outputs: vga_hs=1, vga_vs=1, vga_blank_n=0, rgb=0, fifo_re=0, frame_start=0, underflow=0, hcount=vcount=0.
  - The FIFO is not flushed by this block.
  - Reset mid-frame takes effect on the same edge; on release the frame restarts at h=0, v=0.
- Timing:
  - Line period 800 cycles; frame 525 lines.
  - hs low for hcount 656..751.
  - vs low for lines 490..491.
  - blank_n=1 iff hcount<640 and vcount<480.
  - hcount, vcount, hs, vs, blank_n, rgb and frame_start are registered and mutually aligned. Internal pipeline depth is free.
- Fetch:
  - Only on even active lines (vcount 0, 2 .. 478): exactly 256 fifo_re pulses per line, never on consecutive cycles.
  - The k-th pop of the line is stored at line_buffer[k] and becomes NES column k.
  - No fifo_re on odd lines, in blanking, or in border regions beyond the prefetch required to meet display timing.
- Display:
  - For hcount = X_OFFSET+2k and X_OFFSET+2k+1 (k = 0..255) on lines 2j and 2j+1, rgb = palette[line_buffer[k]].
  - Active pixels outside the window: rgb=0, blank_n=1.
  - Blanking: rgb=0.
- Palette: 64x24 ROM loaded from the team's nes_palette.hex. Indices 0x0D, 0x0E, 0x0F, 0x1D, 0x1E, 0x1F, 0x2E, 0x2F, 0x3E, 0x3F map to 0x000000.
- Underflow:
  - If a pop is due while fifo_empty=1, fifo_re stays 0 and index 0x0F is stored for that column.
  - The remaining columns continue normally; there is no retry and no stall of timing.
  - underflow is set on the next cycle and holds until clr_underflow=1 or reset.
  - A simultaneous set and clear leaves it set.
- FIFO ordering: no frame sync with the PPU. The consumer blindly pops 61440 words per frame.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> hs=1, vs=1, blank_n=0, rgb=0, fifo_re=0, underflow=0. After release hcount steps 0, 1, 2 ... with vcount=0 and frame_start=1 on the first pixel.
- Timing: free-run 2 frames with FIFO never empty:
  - Line period 800; hs low 96 cycles from hcount 656; vs low on lines 490-491.
  - frame_start every 420000 cycles.
- Fetch count: FIFO model never empty -> 256 fifo_re pulses on line 0, 0 on line 1, 256 on line 2, 0 during vertical blanking, 61440 per frame.
- Data and doubling: feed column k index (k mod 64) ->
  - Lines 0 and 1: pixel at hcount 64+2k equals pixel at 65+2k, both = palette[k mod 64].
  - hcount 0..63 and 576..639: rgb=0 with blank_n=1.
  - Index 0x0F -> 0x000000.
- Underflow: assert fifo_empty for all of line 4 ->
  - No fifo_re on line 4; window black on lines 4-5; underflow=1.
  - underflow holds until a clr_underflow pulse, then reads 0.
- Mid-frame reset: pulse reset_n low at vcount 100, hcount 300 ->
  - Next cycle fifo_re=0, underflow=0, outputs at reset values.
  - After release timing restarts at hcount 0, vcount 0.
